// File: rtl/alu_issue_ctrl.sv
// Issue/response controller for an external combinational 32-bit ALU.
// It decodes MIPS-style instructions, holds the ALU inputs in an execute register and buffers one result.
module alu_issue_ctrl #(
    parameter logic [5:0] SGT_FUNCT = 6'h2E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_rs_val,
    input  logic [31:0] req_rt_val,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  alu_shumt,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal,
    output logic [15:0] ops_retired
);

    logic        r_eValid;
    logic        r_eIllegal;
    logic [31:0] r_aluIn1;
    logic [31:0] r_aluIn2;
    logic [3:0]  r_aluCtrl;
    logic [4:0]  r_aluShumt;
    logic        r_rValid;
    logic [31:0] r_rspResult;
    logic        r_rspZero;
    logic        r_rspIllegal;
    logic [15:0] r_opsRetired;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [31:0] w_immSext;
    logic [31:0] w_immZext;
    logic [3:0]  w_ctrl;
    logic [31:0] w_in1;
    logic [31:0] w_in2;
    logic [4:0]  w_shumt;
    logic        w_illegal;
    logic        w_rFree;
    logic        w_advance;
    logic        w_accept;
    logic        w_consume;
    logic [31:0] w_rspData;

    assign w_opcode  = req_instr[31:26];
    assign w_funct   = req_instr[5:0];
    assign w_shamt   = req_instr[10:6];
    assign w_immSext = {{16{req_instr[15]}}, req_instr[15:0]};
    assign w_immZext = {16'h0000, req_instr[15:0]};

    always_comb begin
        w_ctrl    = 4'd0;
        w_in1     = req_rs_val;
        w_in2     = req_rt_val;
        w_shumt   = 5'd0;
        w_illegal = 1'b0;
        if (w_opcode == 6'h00) begin
            case (w_funct)
                6'h20, 6'h21: w_ctrl = 4'd0;
                6'h22, 6'h23: w_ctrl = 4'd1;
                6'h24:        w_ctrl = 4'd2;
                6'h25:        w_ctrl = 4'd3;
                6'h2A:        w_ctrl = 4'd8;
                SGT_FUNCT:    w_ctrl = 4'd7;
                6'h00, 6'h02, 6'h03: begin
                    w_in1   = req_rt_val;
                    w_in2   = 32'd0;
                    w_shumt = w_shamt;
                    w_ctrl  = (w_funct == 6'h00) ? 4'd4 :
                              (w_funct == 6'h02) ? 4'd5 : 4'd6;
                end
                default:      w_illegal = 1'b1;
            endcase
        end else begin
            w_in2 = w_immSext;
            case (w_opcode)
                6'h08, 6'h09, 6'h23, 6'h2B: w_ctrl = 4'd0;
                6'h0A: w_ctrl = 4'd8;
                6'h0C: begin w_ctrl = 4'd2; w_in2 = w_immZext; end
                6'h0D: begin w_ctrl = 4'd3; w_in2 = w_immZext; end
                6'h04, 6'h05: begin w_ctrl = 4'd1; w_in2 = req_rt_val; end
                default: w_illegal = 1'b1;
            endcase
        end
        // Illegal ops present an all-zero operand set to the ALU.
        if (w_illegal) begin
            w_ctrl  = 4'd0;
            w_in1   = 32'd0;
            w_in2   = 32'd0;
            w_shumt = 5'd0;
        end
    end

    assign w_rFree   = !r_rValid || rsp_ready;
    assign w_advance = r_eValid && w_rFree;
    assign req_ready = !rst && (!r_eValid || w_rFree);
    assign w_accept  = req_valid && req_ready;
    assign w_consume = r_rValid && rsp_ready;
    assign w_rspData = r_eIllegal ? 32'd0 : alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eValid   <= 1'b0;
            r_eIllegal <= 1'b0;
            r_aluIn1   <= 32'd0;
            r_aluIn2   <= 32'd0;
            r_aluCtrl  <= 4'd0;
            r_aluShumt <= 5'd0;
        end else if (w_accept) begin
            r_eValid   <= 1'b1;
            r_eIllegal <= w_illegal;
            r_aluIn1   <= w_in1;
            r_aluIn2   <= w_in2;
            r_aluCtrl  <= w_ctrl;
            r_aluShumt <= w_shumt;
        end else if (w_advance) begin
            r_eValid <= 1'b0;
        end
    end

    // The response buffer refills on the same edge it is drained, so a stream never bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rValid     <= 1'b0;
            r_rspResult  <= 32'd0;
            r_rspZero    <= 1'b0;
            r_rspIllegal <= 1'b0;
        end else if (w_advance) begin
            r_rValid     <= 1'b1;
            r_rspResult  <= w_rspData;
            r_rspZero    <= (w_rspData == 32'd0);
            r_rspIllegal <= r_eIllegal;
        end else if (w_consume) begin
            r_rValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opsRetired <= 16'd0;
        end else if (w_consume) begin
            r_opsRetired <= r_opsRetired + 16'd1;
        end
    end

    assign alu_in1     = r_aluIn1;
    assign alu_in2     = r_aluIn2;
    assign alu_ctrl    = r_aluCtrl;
    assign alu_shumt   = r_aluShumt;
    assign rsp_valid   = r_rValid;
    assign rsp_result  = r_rspResult;
    assign rsp_zero    = r_rspZero;
    assign rsp_illegal = r_rspIllegal;
    assign ops_retired = r_opsRetired;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs_val;
    logic [31:0] req_rt_val;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shumt;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;
    logic [15:0] ops_retired;

    typedef struct packed {
        logic [31:0] result;
        logic        illegal;
    } expT;

    expT         sbQ[$];
    expT         popped;
    int          total = 0;
    int          bad = 0;
    int          retiredCount = 0;
    int          cycleCnt = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_shumt(alu_shumt),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .ops_retired(ops_retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural stand-in for the external combinational ALU.
    function automatic logic [31:0] aluModel(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] s);
        logic signed [31:0] sa;
        sa = a;
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << s;
            4'd5: return a >> s;
            4'd6: return sa >>> s;
            4'd7: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = aluModel(alu_ctrl, alu_in1, alu_in2, alu_shumt);

    // Architectural result of an instruction, computed straight from the instruction semantics.
    function automatic expT refExpected(input logic [31:0] ins, input logic [31:0] rs,
                                        input logic [31:0] rt);
        expT e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] sh;
        logic [31:0] se;
        logic [31:0] ze;
        logic signed [31:0] srt;
        op = ins[31:26];
        fn = ins[5:0];
        sh = ins[10:6];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        srt = rt;
        e.result = 32'd0;
        e.illegal = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: e.result = rs + rt;
                6'h22, 6'h23: e.result = rs - rt;
                6'h24: e.result = rs & rt;
                6'h25: e.result = rs | rt;
                6'h00: e.result = rt << sh;
                6'h02: e.result = rt >> sh;
                6'h03: e.result = srt >>> sh;
                6'h2A: e.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2E: e.result = ($signed(rs) > $signed(rt)) ? 32'd1 : 32'd0;
                default: e.illegal = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h23, 6'h2B: e.result = rs + se;
                6'h0A: e.result = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0C: e.result = rs & ze;
                6'h0D: e.result = rs | ze;
                6'h04, 6'h05: e.result = rs - rt;
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Handshakes are judged mid-cycle, when inputs and combinational ready have settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready)
                sbQ.push_back(refExpected(req_instr, req_rs_val, req_rt_val));
            if (rsp_valid && rsp_ready) begin
                retiredCount++;
                if (sbQ.size() == 0) begin
                    checkOutput("rspUnexpected", 32'd1, 32'd0);
                end else begin
                    popped = sbQ.pop_front();
                    checkOutput("rspResult", rsp_result, popped.result);
                    checkOutput("rspZero", {31'd0, rsp_zero}, {31'd0, popped.result == 32'd0});
                    checkOutput("rspIllegal", {31'd0, rsp_illegal}, {31'd0, popped.illegal});
                end
            end
        end
    end

    // Presents one request and returns 1 ns after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        req_valid  = 1'b1;
        req_instr  = ins;
        req_rs_val = rs;
        req_rt_val = rt;
        while (!done && n < 20) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) checkOutput("reqTimeout", 32'd0, 32'd1);
    endtask

    task automatic idleReq();
        req_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [31:0] templates [0:12];
    logic [31:0] bpInstr [0:3];
    logic [31:0] bpRs [0:3];
    logic [31:0] bpRt [0:3];

    initial begin
        int k;
        int c0;
        int guard;
        logic [31:0] snapIn1, snapIn2, snapRes;
        logic [3:0]  snapCtrl;
        logic [4:0]  snapSh;
        logic        snapValid;

        templates[0]  = 32'h00000020;
        templates[1]  = 32'h00000022;
        templates[2]  = 32'h00000024;
        templates[3]  = 32'h00000025;
        templates[4]  = 32'h00000000;
        templates[5]  = 32'h00000002;
        templates[6]  = 32'h00000003;
        templates[7]  = 32'h0000002A;
        templates[8]  = 32'h0000002E;
        templates[9]  = 32'h20000000;
        templates[10] = 32'h34000000;
        templates[11] = 32'h10000000;
        templates[12] = 32'hFC000000;

        rst = 1'b1;
        req_valid = 1'b0;
        req_instr = 32'd0;
        req_rs_val = 32'd0;
        req_rt_val = 32'd0;
        rsp_ready = 1'b1;
        #12;
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd0);
        checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstAluIn1", alu_in1, 32'd0);
        checkOutput("rstOps", {16'd0, ops_retired}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("postRstReqReady", {31'd0, req_ready}, 32'd1);

        // add $3,$1,$2 with latency checks
        applyStimulus(32'h00221820, 32'd5, 32'd7);
        idleReq();
        checkOutput("addCtrl", {28'd0, alu_ctrl}, 32'd0);
        checkOutput("addIn1", alu_in1, 32'd5);
        checkOutput("addIn2", alu_in2, 32'd7);
        checkOutput("addRspEarly", {31'd0, rsp_valid}, 32'd0);
        waitCycles(1);
        checkOutput("addRspValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("addRspResult", rsp_result, 32'd12);
        waitCycles(1);
        checkOutput("addOps", {16'd0, ops_retired}, 32'd1);

        applyStimulus({6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, 32'd0, 32'h80000000);
        idleReq();
        checkOutput("sraCtrl", {28'd0, alu_ctrl}, 32'd6);
        checkOutput("sraIn1", alu_in1, 32'h80000000);
        checkOutput("sraIn2", alu_in2, 32'd0);
        checkOutput("sraShumt", {27'd0, alu_shumt}, 32'd4);
        waitCycles(1);
        checkOutput("sraResult", rsp_result, 32'hF8000000);
        waitCycles(1);

        applyStimulus({6'h0C, 5'd1, 5'd2, 16'hFFFF}, 32'h12345678, 32'd0);
        idleReq();
        checkOutput("andiIn2", alu_in2, 32'h0000FFFF);
        checkOutput("andiCtrl", {28'd0, alu_ctrl}, 32'd2);
        waitCycles(2);

        applyStimulus({6'h0A, 5'd1, 5'd2, 16'hFFFF}, 32'd0, 32'd0);
        idleReq();
        checkOutput("sltiIn2", alu_in2, 32'hFFFFFFFF);
        checkOutput("sltiCtrl", {28'd0, alu_ctrl}, 32'd8);
        waitCycles(2);

        applyStimulus(32'hFC000000, 32'h11111111, 32'h22222222);
        idleReq();
        checkOutput("illCtrl", {28'd0, alu_ctrl}, 32'd0);
        checkOutput("illIn1", alu_in1, 32'd0);
        waitCycles(1);
        checkOutput("illFlag", {31'd0, rsp_illegal}, 32'd1);
        checkOutput("illZero", {31'd0, rsp_zero}, 32'd1);
        waitCycles(1);

        // Back-to-back mixed stream: one acceptance per cycle with no stalls
        c0 = cycleCnt;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(templates[$urandom_range(12)] | ($urandom() & 32'h03FFFFC0),
                          $urandom(), $urandom());
        end
        idleReq();
        checkOutput("streamCycles", cycleCnt - c0, 32'd12);
        waitCycles(3);
        checkOutput("streamDrained", sbQ.size(), 32'd0);

        // Backpressure: four requests offered, only two fit
        for (int i = 0; i < 4; i++) begin
            bpInstr[i] = templates[i] | ($urandom() & 32'h03FFFFC0);
            bpRs[i] = $urandom();
            bpRt[i] = $urandom();
        end
        rsp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1;
            req_instr = bpInstr[k];
            req_rs_val = bpRs[k];
            req_rt_val = bpRt[k];
            @(negedge clk);
            if (req_ready) k++;
            @(posedge clk);
            #1;
        end
        checkOutput("bpAccepted", k, 32'd2);
        checkOutput("bpReqReady", {31'd0, req_ready}, 32'd0);
        snapIn1 = alu_in1;
        snapIn2 = alu_in2;
        snapCtrl = alu_ctrl;
        snapSh = alu_shumt;
        snapRes = rsp_result;
        snapValid = rsp_valid;
        waitCycles(3);
        checkOutput("bpHoldIn1", alu_in1, snapIn1);
        checkOutput("bpHoldIn2", alu_in2, snapIn2);
        checkOutput("bpHoldCtrl", {28'd0, alu_ctrl}, {28'd0, snapCtrl});
        checkOutput("bpHoldSh", {27'd0, alu_shumt}, {27'd0, snapSh});
        checkOutput("bpHoldRes", rsp_result, snapRes);
        checkOutput("bpHoldValid", {31'd0, rsp_valid}, {31'd0, snapValid});
        checkOutput("bpRspValid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        guard = 0;
        while (k < 4 && guard < 20) begin
            req_instr = bpInstr[k];
            req_rs_val = bpRs[k];
            req_rt_val = bpRt[k];
            @(negedge clk);
            if (req_ready) k++;
            @(posedge clk);
            #1;
            guard++;
        end
        idleReq();
        checkOutput("bpReleaseCycles", guard, 32'd2);
        waitCycles(4);
        checkOutput("bpDrained", sbQ.size(), 32'd0);
        checkOutput("bpOps", {16'd0, ops_retired}, retiredCount & 32'hFFFF);

        // Reset with both stages full
        rsp_ready = 1'b0;
        applyStimulus(32'h00221820, 32'd1, 32'd2);
        applyStimulus(32'h00221822, 32'd9, 32'd4);
        idleReq();
        waitCycles(1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstRspValid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midRstOps", {16'd0, ops_retired}, 32'd0);
        checkOutput("midRstAluIn1", alu_in1, 32'd0);
        checkOutput("midRstAluCtrl", {28'd0, alu_ctrl}, 32'd0);
        checkOutput("midRstReqReady", {31'd0, req_ready}, 32'd0);
        sbQ.delete();
        retiredCount = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        applyStimulus(32'h00221820, 32'd100, 32'd23);
        idleReq();
        checkOutput("postRstIn1", alu_in1, 32'd100);
        checkOutput("postRstEarly", {31'd0, rsp_valid}, 32'd0);
        waitCycles(1);
        checkOutput("postRstValid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("postRstResult", rsp_result, 32'd123);
        waitCycles(1);
        checkOutput("postRstOps", {16'd0, ops_retired}, 32'd1);
        checkOutput("finalSbEmpty", sbQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
